riscv_single_cycle_top: RTL and testbench



---
 rtl/riscv_pkg.sv | 109 ++++++++++
 rtl/riscv_dmem_if.sv | 19 +
 rtl/riscv_datapath.sv | 198 +++++++++++++++++++
 rtl/riscv_single_cycle_top.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_single_cycle_top.sv | 124 ++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared RV32I-subset encodings, control types and ROM encoders
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int WIDTH = 32;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_REL  = 2'd1,
    PC_JALR = 2'd2
  } pc_sel_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     alu_src;
    alu_op_t  alu_op;
    imm_sel_t imm_sel;
    wb_sel_t  wb_sel;
  } ctrl_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
  endfunction

  // Branch/jump offsets are byte offsets; bit 0 is implicitly zero in the encoding
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] off);
    logic unused_lsb;
    unused_lsb = off[0];
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    logic unused_lsb;
    unused_lsb = off[0];
    return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, OP_LUI};
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_dmem_if.sv
// ============================================================================
// riscv_dmem_if : CPU <-> data RAM bus (address, write data/enable, read data)
// Rev 1.0
// ============================================================================
`default_nettype none

interface riscv_dmem_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

`default_nettype wire

// File: rtl/riscv_datapath.sv
// ============================================================================
// riscv_datapath : PC register, register file, ALU, immediate generator, muxes
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_pc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clk) begin
    if (rst_n) out <= '0;
    else       out <= D;
  end
endmodule

module riscv_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic [WIDTH-1:0] DataD,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o
);
  logic [WIDTH-1:0] regfile [32];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we_i && (rd_i != 5'd0)) begin
      regfile[rd_i] <= DataD;
    end
  end

  assign rd1_o = (rs1_i == 5'd0) ? '0 : regfile[rs1_i];
  assign rd2_o = (rs2_i == 5'd0) ? '0 : regfile[rs2_i];
endmodule

module riscv_alu
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] C
);
  always_comb begin
    C = A + B;
    case (op_i)
      ALU_ADD:   C = A + B;
      ALU_SUB:   C = A - B;
      ALU_AND:   C = A & B;
      ALU_OR:    C = A | B;
      ALU_SLT:   C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_PASSB: C = B;
      default:   C = A + B;
    endcase
  end
endmodule

module riscv_mux3
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  wb_sel_t          SEL,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = A;
    case (SEL)
      WB_ALU:  out = A;
      WB_MEM:  out = B;
      WB_PC4:  out = C;
      default: out = A;
    endcase
  end
endmodule

module riscv_datapath
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  ctrl_t            ctrl_i,
  input  pc_sel_t          pc_sel_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             eq_o,
  riscv_dmem_if.master     dmem
);
  logic [31:0]      inst;
  logic [WIDTH-1:0] pc_cur;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_target;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] Written_DMem;
  logic             unused_opcode;

  assign inst          = inst_i;
  assign unused_opcode = ^inst[6:0];

  riscv_pc #(.WIDTH(WIDTH)) pc_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (pc_next),
    .out   (pc_cur)
  );

  // All immediate forms are sign-extended from the instruction MSB
  always_comb begin
    imm = '0;
    case (ctrl_i.imm_sel)
      IMM_I:   imm = WIDTH'($signed(inst[31:20]));
      IMM_S:   imm = WIDTH'($signed({inst[31:25], inst[11:7]}));
      IMM_B:   imm = WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_J:   imm = WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      IMM_U:   imm = WIDTH'($signed({inst[31:12], 12'b0}));
      default: imm = '0;
    endcase
  end

  riscv_regfile #(.WIDTH(WIDTH)) RegFile_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (ctrl_i.reg_write),
    .rs1_i (inst[19:15]),
    .rs2_i (inst[24:20]),
    .rd_i  (inst[11:7]),
    .DataD (wb_data),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data)
  );

  assign alu_b = ctrl_i.alu_src ? imm : rs2_data;

  riscv_alu #(.WIDTH(WIDTH)) alu_dut (
    .A    (rs1_data),
    .B    (alu_b),
    .op_i (ctrl_i.alu_op),
    .C    (alu_result)
  );

  riscv_mux3 #(.WIDTH(WIDTH)) mux_3x1_dut1 (
    .A   (alu_result),
    .B   (dmem.rdata),
    .C   (pc_plus4),
    .SEL (ctrl_i.wb_sel),
    .out (wb_data)
  );

  assign pc_plus4  = pc_cur + WIDTH'(4);
  assign pc_target = pc_cur + imm;

  // jalr target comes from the ALU (rs1 + immI) with bit 0 forced low
  always_comb begin
    pc_next = pc_plus4;
    case (pc_sel_i)
      PC_SEQ:  pc_next = pc_plus4;
      PC_REL:  pc_next = pc_target;
      PC_JALR: pc_next = alu_result & ~WIDTH'(1);
      default: pc_next = pc_plus4;
    endcase
  end

  assign eq_o         = (rs1_data == rs2_data);
  assign pc_o         = pc_cur;
  assign address      = alu_result;
  assign Written_DMem = rs2_data;
  assign dmem.addr    = address;
  assign dmem.wdata   = Written_DMem;
  assign dmem.we      = ctrl_i.mem_write;
endmodule

`default_nettype wire

// File: rtl/riscv_single_cycle_top.sv
// ============================================================================
// riscv_single_cycle_top : single-cycle RV32I-subset CPU with program ROM and data RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_imem
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH,
  parameter int WORDS = 64
) (
  input  logic [WIDTH-1:0] addr,
  output logic [31:0]      instruction
);
  localparam int AW = $clog2(WORDS);

  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[WIDTH-1:AW+2], addr[1:0]};

  // Built-in program; branch/jump offsets are target minus instruction address
  always_comb begin
    instruction = INSTR_NOP;
    case (int'(idx))
      0:  instruction = enc_i(OP_IMM, F3_ADD, 5'd2, 5'd0, 12'd5);
      1:  instruction = enc_i(OP_IMM, F3_ADD, 5'd3, 5'd0, 12'd12);
      2:  instruction = enc_i(OP_IMM, F3_ADD, 5'd7, 5'd3, 12'hFF7);
      3:  instruction = enc_r(F7_BASE, F3_OR, 5'd4, 5'd7, 5'd2);
      4:  instruction = enc_r(F7_BASE, F3_AND, 5'd5, 5'd3, 5'd4);
      5:  instruction = enc_r(F7_BASE, F3_ADD, 5'd5, 5'd5, 5'd4);
      6:  instruction = enc_b(F3_BEQ, 5'd5, 5'd7, 13'h030);
      7:  instruction = enc_r(F7_BASE, F3_SLT, 5'd4, 5'd3, 5'd4);
      8:  instruction = enc_b(F3_BEQ, 5'd4, 5'd0, 13'h008);
      9:  instruction = enc_i(OP_IMM, F3_ADD, 5'd5, 5'd0, 12'd0);
      10: instruction = enc_r(F7_BASE, F3_SLT, 5'd4, 5'd7, 5'd2);
      11: instruction = enc_r(F7_BASE, F3_ADD, 5'd7, 5'd4, 5'd5);
      12: instruction = enc_r(F7_SUB, F3_ADD, 5'd7, 5'd7, 5'd2);
      13: instruction = enc_s(5'd7, 5'd3, 12'd84);
      14: instruction = enc_i(OP_LOAD, F3_W, 5'd2, 5'd0, 12'd96);
      15: instruction = enc_r(F7_BASE, F3_ADD, 5'd9, 5'd2, 5'd5);
      16: instruction = enc_j(5'd3, 21'h000008);
      17: instruction = enc_i(OP_IMM, F3_ADD, 5'd2, 5'd0, 12'd1);
      18: instruction = enc_r(F7_BASE, F3_ADD, 5'd2, 5'd2, 5'd9);
      19: instruction = enc_s(5'd2, 5'd3, 12'h020);
      20: instruction = enc_u(5'd20, 20'h12345);
      21: instruction = enc_u(5'd23, 20'h002C0);
      22: instruction = enc_r(F7_BASE, F3_AND, 5'd6, 5'd0, 5'd23);
      23: instruction = enc_b(F3_BEQ, 5'd0, 5'd0, 13'h008);
      24: instruction = enc_i(OP_IMM, F3_ADD, 5'd6, 5'd0, 12'd1);
      25: instruction = enc_j(5'd0, 21'h000004);
      26: instruction = enc_i(OP_JALR, F3_JALR, 5'd21, 5'd0, 12'd8);
      default: instruction = INSTR_NOP;
    endcase
  end
endmodule

module riscv_dmem #(
  parameter int WIDTH = 32,
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  riscv_dmem_if.slave bus
);
  localparam int AW = $clog2(WORDS);

  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] ram [WORDS];
  logic [AW-1:0]    idx;
  logic             unused_addr_bits;

  assign addr             = bus.addr;
  assign din              = bus.wdata;
  // Byte offset is dropped and upper bits ignored, so accesses wrap over the array
  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[WIDTH-1:AW+2], addr[1:0]};
  assign bus.rdata        = ram[idx];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= '0;
    end else if (bus.we) begin
      ram[idx] <= din;
    end
  end
endmodule

module riscv_cpu
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  riscv_dmem_if.master     dmem
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       eq;
  logic       f3_valid;
  alu_op_t    f3_op;
  ctrl_t      ctrl;
  pc_sel_t    pc_sel;

  assign opcode    = imem_instr_i[6:0];
  assign funct3    = imem_instr_i[14:12];
  assign funct7_b5 = imem_instr_i[30];

  // Register and immediate ALU forms share the funct3 -> operation mapping
  always_comb begin
    f3_valid = 1'b1;
    f3_op    = ALU_ADD;
    case (funct3)
      F3_ADD:  f3_op = ALU_ADD;
      F3_SLT:  f3_op = ALU_SLT;
      F3_OR:   f3_op = ALU_OR;
      F3_AND:  f3_op = ALU_AND;
      default: f3_valid = 1'b0;
    endcase
  end

  always_comb begin
    ctrl.reg_write = 1'b0;
    ctrl.mem_write = 1'b0;
    ctrl.alu_src   = 1'b0;
    ctrl.alu_op    = ALU_ADD;
    ctrl.imm_sel   = IMM_I;
    ctrl.wb_sel    = WB_ALU;
    pc_sel         = PC_SEQ;
    case (opcode)
      OP_REG: begin
        ctrl.reg_write = f3_valid;
        ctrl.alu_op    = (funct3 == F3_ADD && funct7_b5) ? ALU_SUB : f3_op;
      end
      OP_IMM: begin
        ctrl.reg_write = f3_valid;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = f3_op;
      end
      OP_LOAD: begin
        ctrl.reg_write = (funct3 == F3_W);
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = (funct3 == F3_W);
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.imm_sel = IMM_B;
        if ((funct3 == F3_BEQ && eq) || (funct3 == F3_BNE && !eq)) pc_sel = PC_REL;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.wb_sel    = WB_PC4;
        pc_sel         = PC_REL;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.wb_sel    = WB_PC4;
          pc_sel         = PC_JALR;
        end
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_op    = ALU_PASSB;
      end
      default: pc_sel = PC_SEQ;
    endcase
  end

  riscv_datapath #(.WIDTH(WIDTH)) Dpath_DUT (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst_i   (imem_instr_i),
    .ctrl_i   (ctrl),
    .pc_sel_i (pc_sel),
    .pc_o     (imem_addr_o),
    .eq_o     (eq),
    .dmem     (dmem)
  );
endmodule

module riscv_single_cycle_top #(
  parameter int WIDTH      = riscv_pkg::WIDTH,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst_n
);
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_instr;

  riscv_dmem_if #(.WIDTH(WIDTH)) dmem_bus ();

  riscv_cpu #(.WIDTH(WIDTH)) cpu_DUT (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .dmem         (dmem_bus)
  );

  riscv_imem #(.WIDTH(WIDTH), .WORDS(IMEM_WORDS)) Imem_DUT (
    .addr        (imem_addr),
    .instruction (imem_instr)
  );

  riscv_dmem #(.WIDTH(WIDTH), .WORDS(DMEM_WORDS)) Dmem_DUT (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dmem_bus)
  );
endmodule

`default_nettype wire

// File: tb/tb_riscv_single_cycle_top.sv
// ============================================================================
// tb_riscv_single_cycle_top : directed program-trace bench via hierarchical probes
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_single_cycle_top;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  riscv_single_cycle_top #(.WIDTH(32), .IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  // Mirror of the internal data bus for store-transaction checks
  riscv_dmem_if #(.WIDTH(32)) probe_bus ();
  assign probe_bus.addr  = dut.Dmem_DUT.addr;
  assign probe_bus.wdata = dut.Dmem_DUT.din;
  assign probe_bus.we    = dut.dmem_bus.we;
  assign probe_bus.rdata = dut.dmem_bus.rdata;

  function automatic logic [31:0] xr(input logic [4:0] n);
    return dut.cpu_DUT.Dpath_DUT.RegFile_dut.regfile[n];
  endfunction

  function automatic logic [31:0] ram(input logic [5:0] i);
    return dut.Dmem_DUT.ram[i];
  endfunction

  function automatic logic [31:0] pc();
    return dut.cpu_DUT.Dpath_DUT.pc_dut.out;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held for one edge
    rst_n = 1'b1;
    step();
    check("reset_pc", pc(), 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), xr(5'(i)), 32'h0);
    rst_n = 1'b0;

    // ALU chain
    step(); check("addi_x2", xr(5'd2), 32'd5); check("pc_after_1", pc(), 32'h04);
    step(); check("addi_x3", xr(5'd3), 32'h0C);
    step(); check("addi_neg_x7", xr(5'd7), 32'd3);
    step(); check("or_x4", xr(5'd4), 32'd7);
    step(); check("and_x5", xr(5'd5), 32'd4);
    step(); check("add_x5", xr(5'd5), 32'd11);

    // Branches
    step(); check("beq_not_taken_pc", pc(), 32'h1C);
    step(); check("slt_false_x4", xr(5'd4), 32'd0);
    step(); check("beq_taken_pc", pc(), 32'h28);
    check("skipped_addi_x5", xr(5'd5), 32'd11);
    step(); check("slt_true_x4", xr(5'd4), 32'd1);
    step(); check("add_x7", xr(5'd7), 32'd12);
    step(); check("sub_x7", xr(5'd7), 32'd7);

    // Memory
    check("sw_bus_we", {31'd0, probe_bus.we}, 32'd1);
    check("sw_bus_addr", probe_bus.addr, 32'h60);
    check("sw_bus_wdata", probe_bus.wdata, 32'd7);
    step(); check("sw_ram_60", ram(6'd24), 32'd7);
    step(); check("lw_x2", xr(5'd2), 32'd7);
    step(); check("add_x9", xr(5'd9), 32'd18);
    step(); check("jal_pc", pc(), 32'h48); check("jal_link_x3", xr(5'd3), 32'h44);
    step(); check("add_x2", xr(5'd2), 32'd25);
    step(); check("sw_ram_64", ram(6'd25), 32'd25);

    // Upper immediates and jumps
    step(); check("lui_x20", xr(5'd20), 32'h1234_5000);
    step(); check("lui_x23", xr(5'd23), 32'h002C_0000);
    step(); check("and_x0_x6", xr(5'd6), 32'd0);
    step(); check("beq_x0_pc", pc(), 32'h64);
    step(); check("jal_x0_pc", pc(), 32'h68); check("x0_after_jal", xr(5'd0), 32'd0);
    check("wb_sel_jalr", {30'd0, dut.cpu_DUT.Dpath_DUT.mux_3x1_dut1.SEL}, 32'd2);
    check("wb_out_jalr", dut.cpu_DUT.Dpath_DUT.mux_3x1_dut1.out, 32'h6C);
    check("alu_jalr", dut.cpu_DUT.Dpath_DUT.alu_dut.C, 32'h08);
    check("next_pc_jalr", dut.cpu_DUT.Dpath_DUT.pc_dut.D, 32'h08);
    step(); check("jalr_link_x21", xr(5'd21), 32'h6C); check("jalr_pc", pc(), 32'h08);
    check("x0_final", xr(5'd0), 32'd0);

    // Restart the program, then reset in the middle of it at PC 0x30
    rst_n = 1'b1;
    step();
    check("rerun_reset_ram", ram(6'd24), 32'd0);
    check("rerun_reset_x9", xr(5'd9), 32'd0);
    rst_n = 1'b0;
    repeat (11) step();
    check("rerun_pc_30", pc(), 32'h30);
    check("rerun_x7_before", xr(5'd7), 32'd12);
    rst_n = 1'b1;
    step();
    check("midreset_pc", pc(), 32'h0);
    check("midreset_x7_no_write", xr(5'd7), 32'd0);
    check("midreset_x2", xr(5'd2), 32'd0);
    check("midreset_x5", xr(5'd5), 32'd0);
    rst_n = 1'b0;
    step(); check("restart_x2", xr(5'd2), 32'd5); check("restart_pc", pc(), 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
